// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam int unsigned FRAME_BITS         = 11;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

  typedef logic [7:0] scan_code_t;

  localparam scan_code_t SC_BREAK    = 8'hF0;
  localparam scan_code_t SC_EXTENDED = 8'hE0;

  // First ten frame bits are {parity, data[7:0], start}, bit 0 = start.
  function automatic logic frame_valid(input logic [9:0] head, input logic stop_bit);
    return (head[0] == 1'b0) && (stop_bit == 1'b1) && (^head[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/lookup_table.sv
// Set-2 scan code to lowercase ASCII, one-cycle registered output.
module lookup_table (
  input  logic       clock,
  input  logic [7:0] address,
  output logic [7:0] q
);

  logic [7:0] w_ascii;
  logic [7:0] r_q;

  always_comb begin
    w_ascii = 8'h00;
    unique case (address)
      8'h1C: w_ascii = 8'h61;  8'h32: w_ascii = 8'h62;  8'h21: w_ascii = 8'h63;
      8'h23: w_ascii = 8'h64;  8'h24: w_ascii = 8'h65;  8'h2B: w_ascii = 8'h66;
      8'h34: w_ascii = 8'h67;  8'h33: w_ascii = 8'h68;  8'h43: w_ascii = 8'h69;
      8'h3B: w_ascii = 8'h6A;  8'h42: w_ascii = 8'h6B;  8'h4B: w_ascii = 8'h6C;
      8'h3A: w_ascii = 8'h6D;  8'h31: w_ascii = 8'h6E;  8'h44: w_ascii = 8'h6F;
      8'h4D: w_ascii = 8'h70;  8'h15: w_ascii = 8'h71;  8'h2D: w_ascii = 8'h72;
      8'h1B: w_ascii = 8'h73;  8'h2C: w_ascii = 8'h74;  8'h3C: w_ascii = 8'h75;
      8'h2A: w_ascii = 8'h76;  8'h1D: w_ascii = 8'h77;  8'h22: w_ascii = 8'h78;
      8'h35: w_ascii = 8'h79;  8'h1A: w_ascii = 8'h7A;
      8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
      8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
      8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
      8'h46: w_ascii = 8'h39;
      8'h0E: w_ascii = 8'h60;  8'h4E: w_ascii = 8'h2D;  8'h55: w_ascii = 8'h3D;
      8'h5D: w_ascii = 8'h5C;  8'h54: w_ascii = 8'h5B;  8'h5B: w_ascii = 8'h5D;
      8'h4C: w_ascii = 8'h3B;  8'h52: w_ascii = 8'h27;  8'h41: w_ascii = 8'h2C;
      8'h49: w_ascii = 8'h2E;  8'h4A: w_ascii = 8'h2F;  8'h29: w_ascii = 8'h20;
      8'h5A: w_ascii = 8'h0D;  8'h66: w_ascii = 8'h08;  8'h0D: w_ascii = 8'h09;
      8'h76: w_ascii = 8'h1B;
      // Keypad
      8'h70: w_ascii = 8'h30;  8'h69: w_ascii = 8'h31;  8'h72: w_ascii = 8'h32;
      8'h7A: w_ascii = 8'h33;  8'h6B: w_ascii = 8'h34;  8'h73: w_ascii = 8'h35;
      8'h74: w_ascii = 8'h36;  8'h6C: w_ascii = 8'h37;  8'h75: w_ascii = 8'h38;
      8'h7D: w_ascii = 8'h39;  8'h7C: w_ascii = 8'h2A;  8'h7B: w_ascii = 8'h2D;
      8'h79: w_ascii = 8'h2B;  8'h71: w_ascii = 8'h2E;
      default: w_ascii = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    r_q <= w_ascii;
  end

  assign q = r_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scan-code FIFO and ASCII lookup.
// Define PS2_FRAME_CHECK_EN to drop frames with bad start, stop or parity bits.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] ascii
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    r_clk_sync;
  logic [2:0]    r_data_sync;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_fall;
  logic w_bit;
  logic w_done;
  logic w_accept;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_timeout;

  assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit     = r_data_sync[1];
  assign w_done    = w_fall && (r_bit_cnt == 4'(FRAME_BITS - 1));
  assign w_timeout = !w_fall && (r_bit_cnt != 4'd0) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_FRAME_CHECK_EN
  assign w_accept = frame_valid(r_frame, w_bit);
`else
  assign w_accept = 1'b1;
`endif

  assign ready  = (r_count != '0);
  assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop  = !nextdata_n && ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign w_push = w_done && w_accept && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[1:0], ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_bit_cnt <= 4'd0;
      r_frame   <= '0;
      r_to_cnt  <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      if (w_done) begin
        r_bit_cnt <= 4'd0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_frame   <= {w_bit, r_frame[9:1]};
      end
    end else if (w_timeout) begin
      r_bit_cnt <= 4'd0;
      r_to_cnt  <= '0;
    end else if (r_bit_cnt != 4'd0) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_frame[8:1];
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW + 1)'(1);
      end
      if (w_done && w_accept && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign data     = ready ? r_mem[r_rd_ptr] : 8'h00;
  assign overflow = r_overflow;

  lookup_table u_lookup_table (
    .clock   (clk),
    .address (data),
    .q       (ascii)
  );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed self-checking bench for ps2_keyboard.
module tb_ps2_keyboard;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [7:0] ascii;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_keyboard #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .ascii      (ascii)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0), 11);
  endtask

  task automatic pop();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b1;
    repeat (4) @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [10:0] fr;
    int          waited;

    do_reset();
    check_eq("rst_ready", ready, 0);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_ascii", ascii, 8'h00);

    // 0x1C with the stop edge watched to confirm ascii lags data by one cycle
    fr = make_frame(8'h1C, 1'b0);
    check_eq("par_1c", fr[9], 0);
    send_bits(fr, 10);
    @(negedge clk) ps2_data = fr[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    waited = 0;
    while (!ready && waited < 2 * HALF) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_wait", ready, 1);
    check_eq("a_data", data, 8'h1C);
    check_eq("a_ascii_lag", ascii, 8'h00);
    @(negedge clk);
    check_eq("a_ascii", ascii, 8'h61);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    pop();
    check_eq("a_empty", ready, 0);
    check_eq("a_empty_data", data, 8'h00);
    check_eq("a_empty_ascii", ascii, 8'h00);

    // Break then make code, popped one at a time
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_eq("brk_data", data, 8'hF0);
    check_eq("brk_ascii", ascii, 8'h00);
    pop();
    check_eq("brk_data2", data, 8'h1C);
    check_eq("brk_ascii2", ascii, 8'h61);
    pop();
    check_eq("brk_empty", ready, 0);

    // Bad parity
    send_bits(make_frame(8'h1C, 1'b1), 11);
`ifdef PS2_FRAME_CHECK_EN
    check_eq("badpar_ready", ready, 0);
`else
    check_eq("badpar_data", data, 8'h1C);
    pop();
    check_eq("badpar_empty", ready, 0);
`endif

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
      if (i == 8) check_eq("ovf_pre", overflow, 0);
    end
    check_eq("ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("ovf_pop%0d", i), data, 32'(i));
      pop();
    end
    check_eq("ovf_empty", ready, 0);
    check_eq("ovf_sticky", overflow, 1);
    do_reset();
    check_eq("ovf_cleared", overflow, 0);

    // Held pop drains the FIFO and then ignores further strobes
    send_byte(8'h32);
    send_byte(8'h21);
    send_byte(8'h23);
    @(negedge clk) nextdata_n = 1'b0;
    repeat (6) @(negedge clk);
    nextdata_n = 1'b1;
    check_eq("hold_empty", ready, 0);
    send_byte(8'h76);
    check_eq("hold_after", data, 8'h76);
    @(negedge clk);
    check_eq("hold_ascii", ascii, 8'h1B);
    pop();
    check_eq("hold_empty2", ready, 0);

    // Reset mid-frame
    send_bits(make_frame(8'h55, 1'b0), 5);
    do_reset();
    send_byte(8'h29);
    check_eq("mid_data", data, 8'h29);
    check_eq("mid_ascii", ascii, 8'h20);
    pop();
    check_eq("mid_single", ready, 0);

    // Partial frame abandoned by timeout
    send_bits(make_frame(8'h66, 1'b0), 4);
    repeat (TIMEOUT + 20) @(negedge clk);
    send_byte(8'h45);
    check_eq("to_data", data, 8'h45);
    check_eq("to_ascii", ascii, 8'h30);
    pop();
    check_eq("to_single", ready, 0);

    // Keypad code
    send_byte(8'h7C);
    check_eq("kp_ascii", ascii, 8'h2A);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
